// File: rtl/div_controller_pkg.sv
// Shared definitions for the signed divide sequencing controller.
//   - state_t         : controller state encoding
//   - DEFAULT_WIDTH   : operand/result width, matches the divider's DIV_SIZE
//   - DEFAULT_TIMEOUT : cycles allowed in RUN before the watchdog aborts
package div_controller_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/div_controller_sign_fix.sv
// Combinational sign conditioning: converts between a magnitude and a
// two's-complement value. Used both to take |A|, |B| before the divider and
// to re-apply signs to the unsigned quotient/remainder afterwards.
//   mag   in  WIDTH  unsigned magnitude (or signed value to be made positive)
//   neg   in  1      negate when high
//   value out WIDTH  neg ? -mag : mag (the most negative value maps to itself)
module div_controller_sign_fix
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] mag,
  input  logic             neg,
  output logic [WIDTH-1:0] value
);

  assign value = neg ? (~mag + WIDTH'(1)) : mag;

endmodule

// File: rtl/div_controller.sv
// Sequencing controller for the iterative unsigned divider. Latches a signed
// request, feeds magnitudes to the divider, pulses its reset to start it,
// waits for ready (with a watchdog), then sign-corrects and registers the
// result with a one-cycle ready pulse.
//   clock, reset                 clock and synchronous active-high reset
//   ctrl_DIV                     one-cycle request; samples the operands
//   data_operandA/B              signed dividend / divisor
//   data_quotient/remainder      registered signed results
//   data_exception               divide-by-zero or watchdog timeout
//   data_resultRDY               one-cycle pulse when results update
//   busy                         high from the cycle after ctrl_DIV to ready
//   div_start                    one-cycle pulse on the divider's reset
//   div_a, div_b                 |A|, |B| to the divider, held through RUN
//   div_q, div_r, div_rdy        divider results and ready
module div_controller
  import div_controller_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_rdy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic             sign_a;
  logic             sign_b;
  logic             zero_div;
  logic             timed_out;
  logic [WIDTH-1:0] a_copy;
  logic [WD_W-1:0]  wd;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  div_controller_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
    .mag   (data_operandA),
    .neg   (data_operandA[WIDTH-1]),
    .value (mag_a)
  );

  div_controller_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
    .mag   (data_operandB),
    .neg   (data_operandB[WIDTH-1]),
    .value (mag_b)
  );

  // Quotient is negative when the operand signs differ; truncation toward zero
  // falls out of dividing magnitudes.
  div_controller_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .mag   (div_q),
    .neg   (sign_a ^ sign_b),
    .value (q_fixed)
  );

  // Remainder takes the dividend's sign.
  div_controller_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .mag   (div_r),
    .neg   (sign_a),
    .value (r_fixed)
  );

  // NOTE: every register here is assigned with <= so all state updates see the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      zero_div       <= 1'b0;
      timed_out      <= 1'b0;
      a_copy         <= '0;
      wd             <= '0;
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
      div_start      <= 1'b0;
      div_a          <= '0;
      div_b          <= '0;
    end else if (ctrl_DIV) begin
      // A request in any state (re)starts: an operation in flight is dropped
      // without a ready pulse; a pulse already showing in DONE is unaffected.
      sign_a         <= data_operandA[WIDTH-1];
      sign_b         <= data_operandB[WIDTH-1];
      div_a          <= mag_a;
      div_b          <= mag_b;
      a_copy         <= data_operandA;
      zero_div       <= (data_operandB == '0);
      timed_out      <= 1'b0;
      wd             <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
      if (data_operandB == '0) begin
        state     <= FIX;
        div_start <= 1'b0;
      end else begin
        state     <= START;
        div_start <= 1'b1;
      end
    end else begin
      data_resultRDY <= 1'b0;
      div_start      <= 1'b0;
      unique case (state)
        IDLE: ;
        START: begin
          state <= RUN;
          wd    <= '0;
        end
        RUN: begin
          // wd == 0 marks the first RUN cycle, where div_rdy may still be
          // left over from the previous operation.
          if (div_rdy && (wd != '0)) begin
            state <= FIX;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            state     <= FIX;
            timed_out <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        FIX: begin
          if (zero_div) begin
            data_quotient  <= '0;
            data_remainder <= a_copy;
            data_exception <= 1'b1;
          end else if (timed_out) begin
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end else begin
            data_quotient  <= q_fixed;
            data_remainder <= r_fixed;
            data_exception <= 1'b0;
          end
          data_resultRDY <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller. A behavioural divider (pulsed-reset
// start, fixed latency, ready that clears one cycle late so a stale ready is
// visible in the first RUN cycle) drives the DUT. A reference model predicts,
// from signed arithmetic and the documented latencies, the ready cycle,
// busy window, div_start cycles and result values; a monitor compares every
// cycle. Directed tests add hand-computed literal expectations.
module tb_div_controller;

  localparam int W       = 32;
  localparam int TMO     = 40;
  localparam int MAXC    = 2048;

  logic         clock;
  logic         reset;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_quotient;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;
  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         div_rdy;

  div_controller #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_quotient  (data_quotient),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .div_start      (div_start),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_q          (div_q),
    .div_r          (div_r),
    .div_rdy        (div_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- behavioural divider ----------------
  int           lat  = 33;   // cycles from seeing the start to ready
  bit           hang = 1'b0; // stub mode: never assert ready
  logic         start_d;
  int           cnt;
  logic         rdy_q;
  logic [W-1:0] q_q, r_q, a_l, b_l;

  always @(posedge clock) begin
    if (reset) begin
      start_d <= 1'b0;
      cnt     <= 0;
      rdy_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      a_l     <= '0;
      b_l     <= '0;
    end else begin
      start_d <= div_start;
      if (start_d) begin
        a_l   <= div_a;
        b_l   <= div_b;
        cnt   <= lat;
        rdy_q <= 1'b0;
      end else if (cnt == 1) begin
        if (!hang) begin
          rdy_q <= 1'b1;
          q_q   <= a_l / b_l;
          r_q   <= a_l % b_l;
        end
        cnt <= 0;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end
    end
  end

  assign div_rdy = rdy_q;
  assign div_q   = q_q;
  assign div_r   = r_q;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         rdy;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       exc;
  } exp_t;

  exp_t pend[$];
  bit   exp_busy  [0:MAXC-1];
  bit   exp_start [0:MAXC-1];
  bit   mon_en = 1'b0;

  // Anything that would have surfaced after cycle c is cancelled.
  task automatic drop_after(input int c);
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].rdy > c) pend.delete(i);
    for (int n = c + 1; n < MAXC; n++) begin
      exp_busy[n]  = 1'b0;
      exp_start[n] = 1'b0;
    end
  endtask

  task automatic model_request(input int c0, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb;
    drop_after(c0);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      e.rdy = c0 + 2; e.q = '0; e.r = a; e.exc = 1'b1;
    end else begin
      exp_start[c0 + 1] = 1'b1;
      if (hang) begin
        e.rdy = c0 + TMO + 3; e.q = '0; e.r = '0; e.exc = 1'b1;
      end else begin
        e.rdy = c0 + 5 + lat;
        e.q   = 32'(sa / sb);
        e.r   = 32'(sa % sb);
        e.exc = 1'b0;
      end
    end
    for (int n = c0 + 1; n <= e.rdy && n < MAXC; n++) exp_busy[n] = 1'b1;
    pend.push_back(e);
  endtask

  // Monitor: every cycle away from the active edge.
  always @(negedge clock) begin
    if (mon_en && cyc < MAXC) begin
      bit   er;
      exp_t e;
      er = 1'b0;
      e  = '{rdy: 0, q: '0, r: '0, exc: 1'b0};
      foreach (pend[i]) if (pend[i].rdy == cyc) begin er = 1'b1; e = pend[i]; end
      check("mon_result_rdy", 32'(data_resultRDY), 32'(er));
      check("mon_busy",       32'(busy),           32'(exp_busy[cyc]));
      check("mon_div_start",  32'(div_start),      32'(exp_start[cyc]));
      if (er) begin
        check("mon_quotient",  data_quotient,        e.q);
        check("mon_remainder", data_remainder,       e.r);
        check("mon_exception", 32'(data_exception),  32'(e.exc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called aligned just after a rising edge; returns the request cycle.
  task automatic request(input logic [W-1:0] a, input logic [W-1:0] b, output int c0);
    c0 = cyc;
    model_request(c0, a, b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    tick(1);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic expect_result(input string name, input int c0, input int want_lat,
                               input logic [W-1:0] wq, input logic [W-1:0] wr, input logic wexc);
    int rc;
    rc = -1;
    for (int i = 0; i < 80 && rc < 0; i++) begin
      @(negedge clock);
      if (data_resultRDY) rc = cyc;
    end
    check({name, "_latency"}, 32'(rc - c0), 32'(want_lat));
    tick(1);
    check({name, "_q"},   data_quotient,       wq);
    check({name, "_r"},   data_remainder,      wr);
    check({name, "_exc"}, 32'(data_exception), 32'(wexc));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_q"},     data_quotient,        32'h0);
    check({name, "_r"},     data_remainder,       32'h0);
    check({name, "_exc"},   32'(data_exception),  32'h0);
    check({name, "_rdy"},   32'(data_resultRDY),  32'h0);
    check({name, "_busy"},  32'(busy),            32'h0);
    check({name, "_start"}, 32'(div_start),       32'h0);
    check({name, "_div_a"}, div_a,                32'h0);
    check({name, "_div_b"}, div_b,                32'h0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0, c1;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick(2);
    @(negedge clock);
    check_all_zero("reset");
    tick(1);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Basic positive division: latency 5 + lat = 38.
    request(32'd100, 32'd7, c0);
    expect_result("pos", c0, 38, 32'd14, 32'd2, 1'b0);

    // Sign combinations.
    request(-32'sd100, 32'd7, c0);
    expect_result("neg_a", c0, 38, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    request(32'd100, -32'sd7, c0);
    expect_result("neg_b", c0, 38, 32'hFFFF_FFF2, 32'd2, 1'b0);
    request(-32'sd100, -32'sd7, c0);
    expect_result("neg_ab", c0, 38, 32'd14, 32'hFFFF_FFFE, 1'b0);

    // Overflow wraps without exception.
    request(32'h8000_0000, 32'hFFFF_FFFF, c0);
    expect_result("ovf", c0, 38, 32'h8000_0000, 32'h0, 1'b0);

    // Divide by zero bypasses the divider.
    request(32'd5, 32'd0, c0);
    expect_result("zero", c0, 2, 32'h0, 32'd5, 1'b1);

    // Hung divider trips the watchdog.
    hang = 1'b1;
    request(32'd77, 32'd3, c0);
    expect_result("timeout", c0, 43, 32'h0, 32'h0, 1'b1);
    hang = 1'b0;
    tick(2);

    // Abort: new request 10 cycles into RUN; only the second completes.
    request(32'd100, 32'd7, c0);
    tick(c0 + 12 - cyc);
    request(32'd9, 32'd2, c1);
    expect_result("abort", c1, 38, 32'd4, 32'd1, 1'b0);

    // Reset mid-RUN clears everything and suppresses the pulse.
    request(-32'sd100, 32'd7, c0);
    tick(c0 + 10 - cyc);
    reset = 1'b1;
    drop_after(cyc);
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("mid_reset");
    tick(50);

    // Back-to-back: second request in the first one's DONE cycle; the
    // divider's ready is still high from op 1 in op 2's first RUN cycle.
    request(32'd100, 32'd7, c0);
    tick(c0 + 38 - cyc);
    request(-32'sd9, 32'd2, c1);
    expect_result("b2b", c1, 38, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
    tick(5);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
